// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Write-back port arbiter between the in-order pipe result and a
//               one-entry buffered long-latency-unit result, with starvation
//               guard. Optional statistics counters enabled by WB_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int DBITS        = 32,
    parameter int REGNOBITS    = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pipe_valid_i,
    input  logic [REGNOBITS-1:0] pipe_regno_i,
    input  logic [DBITS-1:0]     pipe_data_i,
    output logic                 pipe_stall_o,
    input  logic                 llu_valid_i,
    input  logic [REGNOBITS-1:0] llu_regno_i,
    input  logic [DBITS-1:0]     llu_data_i,
    output logic                 llu_ready_o,
    output logic                 wr_reg_o,
    output logic [REGNOBITS-1:0] wregno_o,
    output logic [DBITS-1:0]     regval_o,
    output logic [31:0]          stat_pipe_wr_o,
    output logic [31:0]          stat_llu_wr_o,
    output logic [31:0]          stat_stall_o
);

    typedef enum logic [0:0] {
        NORMAL    = 1'b0,
        FORCE_LLU = 1'b1
    } state_t;

    localparam logic [3:0] C_STARVE_LIM = 4'(STARVE_LIMIT);

    state_t                 state_q, state_d;
    logic                   buf_full_q, buf_full_d;
    logic [REGNOBITS-1:0]   buf_regno_q, buf_regno_d;
    logic [DBITS-1:0]       buf_data_q, buf_data_d;
    logic [3:0]             starve_cnt_q, starve_cnt_d;
    logic                   wr_reg_q, wr_reg_d;
    logic [REGNOBITS-1:0]   wregno_q, wregno_d;
    logic [DBITS-1:0]       regval_q, regval_d;
    logic                   grant_pipe, grant_buf, pipe_stall;

    always_comb begin
        state_d      = state_q;
        grant_pipe   = 1'b0;
        grant_buf    = 1'b0;
        pipe_stall   = 1'b0;
        buf_full_d   = buf_full_q;
        buf_regno_d  = buf_regno_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        wr_reg_d     = 1'b0;
        wregno_d     = wregno_q;
        regval_d     = regval_q;

        case (state_q)
            NORMAL: begin
                if (pipe_valid_i) begin
                    grant_pipe = 1'b1;
                end else if (buf_full_q) begin
                    grant_buf = 1'b1;
                end
            end
            FORCE_LLU: begin
                grant_buf  = buf_full_q;
                pipe_stall = pipe_valid_i;
            end
            default: ;
        endcase

        if (grant_buf) begin
            starve_cnt_d = 4'd0;
        end else if (buf_full_q) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = 4'd0;
        end

        if (state_q == FORCE_LLU) begin
            state_d = NORMAL;
        end else if (starve_cnt_d == C_STARVE_LIM) begin
            state_d = FORCE_LLU;
        end

        // Loading requires an empty buffer and draining a full one, so the two never coincide.
        if (grant_buf) begin
            buf_full_d = 1'b0;
        end else if (llu_valid_i && !buf_full_q) begin
            buf_full_d  = 1'b1;
            buf_regno_d = llu_regno_i;
            buf_data_d  = llu_data_i;
        end

        if (grant_pipe) begin
            wr_reg_d = (pipe_regno_i != '0);
            wregno_d = pipe_regno_i;
            regval_d = pipe_data_i;
        end else if (grant_buf) begin
            wr_reg_d = (buf_regno_q != '0);
            wregno_d = buf_regno_q;
            regval_d = buf_data_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= NORMAL;
            buf_full_q   <= 1'b0;
            buf_regno_q  <= '0;
            buf_data_q   <= '0;
            starve_cnt_q <= 4'd0;
            wr_reg_q     <= 1'b0;
            wregno_q     <= '0;
            regval_q     <= '0;
        end else begin
            state_q      <= state_d;
            buf_full_q   <= buf_full_d;
            buf_regno_q  <= buf_regno_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            wr_reg_q     <= wr_reg_d;
            wregno_q     <= wregno_d;
            regval_q     <= regval_d;
        end
    end

    assign pipe_stall_o = pipe_stall;
    assign llu_ready_o  = !buf_full_q;
    assign wr_reg_o     = wr_reg_q;
    assign wregno_o     = wregno_q;
    assign regval_o     = regval_q;

`ifdef WB_ARB_STATS_EN
    logic [31:0] stat_pipe_wr_q, stat_llu_wr_q, stat_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_pipe_wr_q <= 32'd0;
            stat_llu_wr_q  <= 32'd0;
            stat_stall_q   <= 32'd0;
        end else begin
            if (grant_pipe && (pipe_regno_i != '0)) stat_pipe_wr_q <= stat_pipe_wr_q + 32'd1;
            if (grant_buf && (buf_regno_q != '0))   stat_llu_wr_q  <= stat_llu_wr_q + 32'd1;
            if (pipe_stall)                          stat_stall_q   <= stat_stall_q + 32'd1;
        end
    end

    assign stat_pipe_wr_o = stat_pipe_wr_q;
    assign stat_llu_wr_o  = stat_llu_wr_q;
    assign stat_stall_o   = stat_stall_q;
`else
    assign stat_pipe_wr_o = 32'd0;
    assign stat_llu_wr_o  = 32'd0;
    assign stat_stall_o   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed scoreboard bench for wb_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DBITS     = 32;
    localparam int REGNOBITS = 5;
`ifdef WB_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 pipe_valid = 1'b0;
    logic [REGNOBITS-1:0] pipe_regno = '0;
    logic [DBITS-1:0]     pipe_data = '0;
    logic                 pipe_stall;
    logic                 llu_valid = 1'b0;
    logic [REGNOBITS-1:0] llu_regno = '0;
    logic [DBITS-1:0]     llu_data = '0;
    logic                 llu_ready;
    logic                 wr_reg;
    logic [REGNOBITS-1:0] wregno;
    logic [DBITS-1:0]     regval;
    logic [31:0]          stat_pipe_wr, stat_llu_wr, stat_stall;

    int n_chk  = 0;
    int n_fail = 0;
    logic [REGNOBITS+DBITS-1:0] exp_q[$];

    always #5 clk = ~clk;

    wb_port_arbiter #(.DBITS(DBITS), .REGNOBITS(REGNOBITS), .STARVE_LIMIT(4)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .pipe_valid_i   (pipe_valid),
        .pipe_regno_i   (pipe_regno),
        .pipe_data_i    (pipe_data),
        .pipe_stall_o   (pipe_stall),
        .llu_valid_i    (llu_valid),
        .llu_regno_i    (llu_regno),
        .llu_data_i     (llu_data),
        .llu_ready_o    (llu_ready),
        .wr_reg_o       (wr_reg),
        .wregno_o       (wregno),
        .regval_o       (regval),
        .stat_pipe_wr_o (stat_pipe_wr),
        .stat_llu_wr_o  (stat_llu_wr),
        .stat_stall_o   (stat_stall)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int rn, input logic [31:0] d);
        exp_q.push_back({5'(rn), d});
    endtask

    // Scoreboard monitor: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && wr_reg) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, wregno, regval}, 64'd0);
            end else begin
                logic [REGNOBITS+DBITS-1:0] e;
                e = exp_q.pop_front();
                chk("wb_regno", 64'(wregno), 64'(e[DBITS +: REGNOBITS]));
                chk("wb_data", 64'(regval), 64'(e[DBITS-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_wr_reg", 64'(wr_reg), 64'd0);
        chk("rst_wregno", 64'(wregno), 64'd0);
        chk("rst_regval", 64'(regval), 64'd0);
        chk("rst_llu_ready", 64'(llu_ready), 64'd1);
        chk("rst_pipe_stall", 64'(pipe_stall), 64'd0);
        chk("rst_stats", {32'(stat_pipe_wr), stat_llu_wr | stat_stall}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pipe-only write
        pipe_valid = 1'b1; pipe_regno = 5'd5; pipe_data = 32'hA5A5_A5A5;
        push(5, 32'hA5A5_A5A5);
        #1 chk("pipe_only_stall", 64'(pipe_stall), 64'd0);
        @(negedge clk);
        pipe_valid = 1'b0;
        chk("pipe_only_wr", 64'(wr_reg), 64'd1);
        @(negedge clk);

        // LLU-only write, two cycles after handshake
        llu_valid = 1'b1; llu_regno = 5'd7; llu_data = 32'h1234_5678;
        push(7, 32'h1234_5678);
        #1 chk("llu_ready_idle", 64'(llu_ready), 64'd1);
        @(negedge clk);
        llu_valid = 1'b0;
        #1 chk("llu_ready_busy", 64'(llu_ready), 64'd0);
        chk("llu_lat_early", 64'(wr_reg), 64'd0);
        @(negedge clk);
        chk("llu_lat_wr", 64'(wr_reg), 64'd1);
        chk("llu_ready_free", 64'(llu_ready), 64'd1);
        @(negedge clk);

        // Register zero is consumed but never written
        pipe_valid = 1'b1; pipe_regno = 5'd0; pipe_data = 32'hFFFF_FFFF;
        @(negedge clk);
        pipe_valid = 1'b0;
        chk("x0_wr_reg", 64'(wr_reg), 64'd0);
        chk("x0_stat_pipe", 64'(stat_pipe_wr), STATS ? 64'd1 : 64'd0);
        @(negedge clk);

        // Starvation: LLU buffered while pipe streams continuously
        for (int i = 0; i < 5; i++) push(10 + i, 32'h1000 + 32'(i));
        push(9, 32'hCAFE_F00D);
        push(15, 32'h1005);
        push(16, 32'h1006);
        w = 0;
        for (int k = 0; k < 8; k++) begin
            pipe_valid = 1'b1; pipe_regno = 5'(10 + w); pipe_data = 32'h1000 + 32'(w);
            llu_valid = (k == 0); llu_regno = 5'd9; llu_data = 32'hCAFE_F00D;
            #1 chk($sformatf("starve_stall_k%0d", k), 64'(pipe_stall), (k == 5) ? 64'd1 : 64'd0);
            if (!pipe_stall) w++;
            @(negedge clk);
        end
        pipe_valid = 1'b0; llu_valid = 1'b0;
        chk("starve_consumed", 64'(w), 64'd7);
        repeat (2) @(negedge clk);

        // Reset mid-operation discards buffered LLU result
        pipe_valid = 1'b1; pipe_regno = 5'd20; pipe_data = 32'h2020_2020;
        llu_valid = 1'b1; llu_regno = 5'd21; llu_data = 32'hDEAD_BEEF;
        push(20, 32'h2020_2020);
        @(negedge clk);
        pipe_valid = 1'b0; llu_valid = 1'b0;
        #1 chk("pre_reset_full", 64'(llu_ready), 64'd0);
        chk("stat_pipe_wr", 64'(stat_pipe_wr), STATS ? 64'd9 : 64'd0);
        chk("stat_llu_wr", 64'(stat_llu_wr), STATS ? 64'd2 : 64'd0);
        chk("stat_stall", 64'(stat_stall), STATS ? 64'd1 : 64'd0);
        #1 rst_n = 1'b0;
        #1 chk("midrst_wr_reg", 64'(wr_reg), 64'd0);
        chk("midrst_llu_ready", 64'(llu_ready), 64'd1);
        chk("midrst_pipe_stall", 64'(pipe_stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_stats", {32'(stat_pipe_wr), stat_llu_wr | stat_stall}, 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
